rx_fifo: RTL and testbench

- Parametrised synchronous FIFO that buffers received UART bytes between the receiver shift logic and the host/read side.
- Replaces the fixed 4-entry, externally-addressed receive buffer. Uses internal read/write pointers, true full/empty/almost-full status, an occupancy count, and sticky overflow/underflow error flags.
- Single clock domain. Read data is registered.

---
 rtl/rx_fifo.sv | 113 +++++++++++
 tb/tb_rx_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: parametrised synchronous receive FIFO for UART bytes.
// Internal wrap-around pointers and an occupancy counter.
// EMPTY, FULL and AFULL are decoded from the registered count.
// OVERFLOW and UNDERFLOW are sticky error flags.
// Read data is registered and qualified by a one-cycle dataValid pulse.
module rx_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned AFULL_TH = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WR,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              RD,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic              EMPTY,
    output logic              FULL,
    output logic              AFULL,
    output logic [ADDR_W:0]   count,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    input  logic              ERR_CLR
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_en, rd_en;

    // Status decode from the registered occupancy
    always_comb begin
        EMPTY = (count_q == '0);
        FULL  = (count_q == DEPTH_C);
        AFULL = (count_q >= AFULL_C);
    end

    // Acceptance, pointer, count, read-data and error-flag next state
    always_comb begin
        wr_en    = WR && !FULL;
        rd_en    = RD && !EMPTY;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        valid_d  = rd_en;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem_q[rd_ptr_q];
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
        // A new error event in the same cycle as ERR_CLR leaves the flag set
        ovf_d = (ERR_CLR ? 1'b0 : ovf_q) | (WR && FULL);
        udf_d = (ERR_CLR ? 1'b0 : udf_q) | (RD && EMPTY);
    end

    // Storage array: written on accepted writes, never reset
    always_ff @(posedge Clk) begin
        if (wr_en && !Rst) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Output drive from registered state
    always_comb begin
        dataOut   = dout_q;
        dataValid = valid_q;
        count     = count_q;
        OVERFLOW  = ovf_q;
        UNDERFLOW = udf_q;
    end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: queue-based reference model plus directed and random stimulus for rx_fifo.
module tb_rx_fifo;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned AFULL_TH = 3;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              WR = 1'b0;
    logic              RD = 1'b0;
    logic              ERR_CLR = 1'b0;
    logic [DATA_W-1:0] dataIn = '0;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid, EMPTY, FULL, AFULL, OVERFLOW, UNDERFLOW;
    logic [ADDR_W:0]   count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_out = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;
    bit                m_live = 1'b0;

    rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)) dut (
        .Clk(Clk), .Rst(Rst), .WR(WR), .dataIn(dataIn), .RD(RD),
        .dataOut(dataOut), .dataValid(dataValid), .EMPTY(EMPTY), .FULL(FULL),
        .AFULL(AFULL), .count(count), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
        .ERR_CLR(ERR_CLR)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous compare of every DUT output against the model, mid-cycle
    always @(negedge Clk) begin
        if (m_live) begin
            chk("count",     32'(count),     32'(m_q.size()));
            chk("EMPTY",     32'(EMPTY),     32'(m_q.size() == 0));
            chk("FULL",      32'(FULL),      32'(m_q.size() == DEPTH));
            chk("AFULL",     32'(AFULL),     32'(m_q.size() >= AFULL_TH));
            chk("dataOut",   32'(dataOut),   32'(m_out));
            chk("dataValid", 32'(dataValid), 32'(m_valid));
            chk("OVERFLOW",  32'(OVERFLOW),  32'(m_ovf));
            chk("UNDERFLOW", 32'(UNDERFLOW), 32'(m_udf));
        end
    end

    // One clock: drive inputs, advance the model across the edge, settle
    task automatic cycle(input bit rst, input bit wr, input bit rd,
                         input logic [DATA_W-1:0] din, input bit clr);
        bit full, empty, wacc, racc;
        Rst = rst; WR = wr; RD = rd; dataIn = din; ERR_CLR = clr;
        @(posedge Clk);
        if (rst) begin
            m_q.delete();
            m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_live = 1'b1;
        end else begin
            full  = (m_q.size() == DEPTH);
            empty = (m_q.size() == 0);
            wacc  = wr && !full;
            racc  = rd && !empty;
            if (racc) m_out = m_q.pop_front();
            if (wacc) m_q.push_back(din);
            m_valid = racc;
            m_ovf = (clr ? 1'b0 : m_ovf) | (wr && full);
            m_udf = (clr ? 1'b0 : m_udf) | (rd && empty);
        end
        #1;
        Rst = 1'b0; WR = 1'b0; RD = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic wr1(input logic [DATA_W-1:0] d);
        cycle(1'b0, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic rd1();
        cycle(1'b0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic rst1();
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] pat [4];
        int wpct, rpct;
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;

        // Reset then idle
        rst1();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("lit_rst_count", 32'(count), 0);
        chk("lit_rst_empty", 32'(EMPTY), 1);
        chk("lit_rst_dout",  32'(dataOut), 0);
        chk("lit_rst_flags", {29'd0, FULL, AFULL, OVERFLOW | UNDERFLOW | dataValid}, 0);

        // Fill to full, then overflow
        for (int i = 0; i < 4; i++) begin
            wr1(pat[i]);
            chk("lit_fill_count", 32'(count), 32'(i + 1));
            chk("lit_fill_afull", 32'(AFULL), 32'(i >= 2));
        end
        chk("lit_full", 32'(FULL), 1);
        wr1(8'hE5);
        chk("lit_ovf", 32'(OVERFLOW), 1);
        chk("lit_ovf_count", 32'(count), 4);

        // Drain back to back, then underflow
        for (int i = 0; i < 4; i++) begin
            rd1();
            chk("lit_drain_dout",  32'(dataOut), 32'(pat[i]));
            chk("lit_drain_valid", 32'(dataValid), 1);
        end
        chk("lit_drain_empty", 32'(EMPTY), 1);
        rd1();
        chk("lit_udf", 32'(UNDERFLOW), 1);
        chk("lit_udf_dout", 32'(dataOut), 32'hD4);
        chk("lit_udf_valid", 32'(dataValid), 0);

        // Streaming across pointer wrap, at most two in flight
        rst1();
        wr1(8'h00);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, i < 9, 1'b1, 8'(i + 1), 1'b0);
            chk("lit_stream_dout", 32'(dataOut), 32'(i));
        end
        chk("lit_stream_err", 32'(OVERFLOW | UNDERFLOW), 0);
        chk("lit_stream_empty", 32'(EMPTY), 1);

        // Simultaneous read/write at count 2
        wr1(8'h11); wr1(8'h22);
        cycle(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
        chk("lit_sim2_count", 32'(count), 2);
        chk("lit_sim2_dout", 32'(dataOut), 32'h11);

        // Simultaneous at empty, then at full
        rst1();
        cycle(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        chk("lit_sim0_count", 32'(count), 1);
        chk("lit_sim0_udf", 32'(UNDERFLOW), 1);
        wr1(8'h55); wr1(8'h66); wr1(8'h77);
        cycle(1'b0, 1'b1, 1'b1, 8'h88, 1'b0);
        chk("lit_sim4_count", 32'(count), 3);
        chk("lit_sim4_ovf", 32'(OVERFLOW), 1);
        chk("lit_sim4_dout", 32'(dataOut), 32'h44);

        // Reset during a read, then clear racing a new overflow
        rst1();
        wr1(8'h01); wr1(8'h02); wr1(8'h03);
        cycle(1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("lit_midrst_count", 32'(count), 0);
        chk("lit_midrst_empty", 32'(EMPTY), 1);
        chk("lit_midrst_valid", 32'(dataValid), 0);
        chk("lit_midrst_dout", 32'(dataOut), 0);
        for (int i = 0; i < 4; i++) wr1(8'(8'h90 + i));
        cycle(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
        chk("lit_clr_ovf", 32'(OVERFLOW), 1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("lit_clr_done", 32'(OVERFLOW), 0);

        // Randomised phases with shifting write/read bias
        for (int ph = 0; ph < 6; ph++) begin
            wpct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            rpct = 100 - wpct;
            for (int n = 0; n < 500; n++) begin
                cycle($urandom_range(199) == 0,
                      $urandom_range(99) < wpct,
                      $urandom_range(99) < rpct,
                      8'($urandom),
                      $urandom_range(15) == 0);
            end
        end

        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
